// File: rtl/mdma_wrb_ctxt_ram_pkg.sv
// Shared types, sizes and SECDED helpers for the MDMA write-back context RAM.
// The optional ECC feature is selected with MDMA_WRB_CTXT_RAM_ECC_EN.
package mdma_wrb_ctxt_ram_pkg;

  localparam int WRB_CTXT_RAM_DEPTH     = 2048;
  localparam int WRB_CTXT_RAM_DATA_BITS = 128;
  localparam int WRB_CTXT_ECC_BITS      = 9;
  localparam int WRB_CTXT_RAM_AW        = $clog2(WRB_CTXT_RAM_DEPTH);
  localparam int WRB_CTXT_HAM_BITS      = WRB_CTXT_ECC_BITS - 1;

  typedef logic [WRB_CTXT_RAM_AW-1:0]        wrb_ctxt_addr_t;
  typedef logic [WRB_CTXT_RAM_DATA_BITS-1:0] wrb_ctxt_data_t;
  typedef logic [WRB_CTXT_HAM_BITS-1:0]      wrb_ctxt_syn_t;

  typedef struct packed {
    logic           par;
    wrb_ctxt_syn_t  chk;
    wrb_ctxt_data_t dat;
  } wrb_ctxt_cw_t;

  // Hamming position (1-based) of data bit idx; powers of two are check-bit slots.
  function automatic wrb_ctxt_syn_t ecc_data_pos(input int unsigned idx);
    int unsigned p;
    p = idx + 1;
    for (int k = 0; k < WRB_CTXT_HAM_BITS; k++) begin
      if ((32'd1 << k) <= p) p = p + 1;
    end
    return wrb_ctxt_syn_t'(p);
  endfunction

  function automatic wrb_ctxt_syn_t ecc_hamming(input wrb_ctxt_data_t d);
    wrb_ctxt_syn_t h;
    h = '0;
    for (int i = 0; i < WRB_CTXT_RAM_DATA_BITS; i++) begin
      if (d[i]) h = h ^ ecc_data_pos(i);
    end
    return h;
  endfunction

  function automatic wrb_ctxt_cw_t ecc_encode(input wrb_ctxt_data_t d);
    wrb_ctxt_cw_t cw;
    cw.dat = d;
    cw.chk = ecc_hamming(d);
    cw.par = ^{cw.chk, d};
    return cw;
  endfunction

  function automatic wrb_ctxt_syn_t ecc_syndrome(input wrb_ctxt_cw_t cw);
    return ecc_hamming(cw.dat) ^ cw.chk;
  endfunction

  function automatic logic addr_in_range(input wrb_ctxt_addr_t a);
    return {1'b0, a} < (WRB_CTXT_RAM_AW + 1)'(WRB_CTXT_RAM_DEPTH);
  endfunction

endpackage

// File: rtl/mdma_128bx2048_128bwe_ram_if.sv
// Context RAM port bundle: m = context controller, s = RAM responder.
interface mdma_128bx2048_128bwe_ram_if;
  import mdma_wrb_ctxt_ram_pkg::*;

  wrb_ctxt_addr_t wadr;
  logic           wen;
  wrb_ctxt_data_t wdat;
  logic           ren;
  wrb_ctxt_addr_t radr;
  wrb_ctxt_data_t rdat;
  logic           rsbe;
  logic           rdbe;

  modport m (output wadr, wen, wdat, ren, radr, input rdat, rsbe, rdbe);
  modport s (input wadr, wen, wdat, ren, radr, output rdat, rsbe, rdbe);
endinterface

// File: rtl/mdma_secded_128.sv
// Combinational SECDED decoder for one 137-bit context word (128 data + 8 Hamming + parity).
module mdma_secded_128
  import mdma_wrb_ctxt_ram_pkg::*;
(
  input  wrb_ctxt_cw_t   cw_i,
  output wrb_ctxt_data_t data_o,
  output logic           sbe_o,
  output logic           dbe_o
);

  wrb_ctxt_syn_t syn;
  logic          par_err;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    data_o  = cw_i.dat;
    sbe_o   = 1'b0;
    dbe_o   = 1'b0;
    syn     = ecc_syndrome(cw_i);
    par_err = ^cw_i;
    if (par_err) begin
      // Odd error count: a zero syndrome means only the parity bit flipped.
      sbe_o = 1'b1;
      for (int i = 0; i < WRB_CTXT_RAM_DATA_BITS; i++) begin
        if (ecc_data_pos(i) == syn) data_o[i] = ~cw_i.dat[i];
      end
    end else if (syn != '0) begin
      dbe_o = 1'b1;
    end
  end

endmodule

// File: rtl/mdma_wrb_ctxt_ram_rsp.sv
// Write-back context RAM responder: 2048 x 128 array, read-first, 2-cycle pipelined reads.
// SECDED protection and error injection are enabled by MDMA_WRB_CTXT_RAM_ECC_EN.
module mdma_wrb_ctxt_ram_rsp
  import mdma_wrb_ctxt_ram_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  mdma_128bx2048_128bwe_ram_if.s        ram,
  input  logic                          inj_sbe,
  input  logic                          inj_dbe
);

`ifdef MDMA_WRB_CTXT_RAM_ECC_EN
  typedef wrb_ctxt_cw_t word_t;
`else
  typedef wrb_ctxt_data_t word_t;
`endif

  word_t          mem [WRB_CTXT_RAM_DEPTH];
  word_t          wr_word;
  logic           mem_we;
  word_t          s1_dat_d, s1_dat_q;
  logic           s1_vld_d, s1_vld_q;
  wrb_ctxt_data_t rdat_d, rdat_q;
  logic           rsbe_d, rsbe_q;
  logic           rdbe_d, rdbe_q;
  wrb_ctxt_data_t dec_data;
  logic           dec_sbe, dec_dbe;

  always_comb begin
`ifdef MDMA_WRB_CTXT_RAM_ECC_EN
    wr_word        = ecc_encode(ram.wdat);
    wr_word.dat[0] = wr_word.dat[0] ^ (inj_sbe | inj_dbe);
    wr_word.dat[1] = wr_word.dat[1] ^ inj_dbe;
`else
    wr_word        = ram.wdat;
`endif
    // A write presented while reset is held low must not land in the array.
    mem_we = ram.wen & rst_n & addr_in_range(ram.wadr);
  end

  // NOTE: the array itself is never reset; the controller initialises locations before use.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ram.wadr] <= wr_word;
  end

  // Stage 1 samples the array before this edge's write lands, giving read-first.
  always_comb begin
    s1_vld_d = ram.ren;
    s1_dat_d = s1_dat_q;
    if (ram.ren) s1_dat_d = addr_in_range(ram.radr) ? mem[ram.radr] : '0;
  end

`ifdef MDMA_WRB_CTXT_RAM_ECC_EN
  mdma_secded_128 u_secded (
    .cw_i   (s1_dat_q),
    .data_o (dec_data),
    .sbe_o  (dec_sbe),
    .dbe_o  (dec_dbe)
  );
`else
  logic unused_inj;
  assign unused_inj = inj_sbe ^ inj_dbe;
  assign dec_data   = s1_dat_q;
  assign dec_sbe    = 1'b0;
  assign dec_dbe    = 1'b0;
`endif

  always_comb begin
    rdat_d = s1_vld_q ? dec_data : rdat_q;
    rsbe_d = s1_vld_q & dec_sbe;
    rdbe_d = s1_vld_q & dec_dbe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      rdat_q   <= '0;
      rsbe_q   <= 1'b0;
      rdbe_q   <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      rdat_q   <= rdat_d;
      rsbe_q   <= rsbe_d;
      rdbe_q   <= rdbe_d;
    end
  end

  assign ram.rdat = rdat_q;
  assign ram.rsbe = rsbe_q;
  assign ram.rdbe = rdbe_q;

endmodule

// File: tb/tb_mdma_wrb_ctxt_ram_rsp.sv
// Directed bench for mdma_wrb_ctxt_ram_rsp: vector table plus hand-written pipeline sequences.
module tb_mdma_wrb_ctxt_ram_rsp;
  import mdma_wrb_ctxt_ram_pkg::*;

`ifdef MDMA_WRB_CTXT_RAM_ECC_EN
  localparam bit ECC_ON = 1'b1;
`else
  localparam bit ECC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic inj_sbe;
  logic inj_dbe;

  always #5 clk = ~clk;

  mdma_128bx2048_128bwe_ram_if ram_if ();

  mdma_wrb_ctxt_ram_rsp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ram     (ram_if.s),
    .inj_sbe (inj_sbe),
    .inj_dbe (inj_dbe)
  );

  typedef struct {
    logic [10:0]  addr;
    logic [127:0] dat;
  } vec_t;

  vec_t vecs [5];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ram_if.wen  = 1'b0;
    ram_if.ren  = 1'b0;
    inj_sbe     = 1'b0;
    inj_dbe     = 1'b0;
  endtask

  task automatic write(input logic [10:0] a, input logic [127:0] d, input logic sbe, input logic dbe);
    ram_if.wen  = 1'b1;
    ram_if.wadr = a;
    ram_if.wdat = d;
    inj_sbe     = sbe;
    inj_dbe     = dbe;
    step();
    idle();
  endtask

  task automatic read_check(input string name, input logic [10:0] a, input logic [127:0] exp_d,
                            input logic exp_s, input logic exp_b);
    ram_if.ren  = 1'b1;
    ram_if.radr = a;
    step();
    ram_if.ren  = 1'b0;
    step();
    check({name, ".rdat"}, ram_if.rdat, exp_d);
    check({name, ".rsbe"}, 128'(ram_if.rsbe), 128'(exp_s));
    check({name, ".rdbe"}, 128'(ram_if.rdbe), 128'(exp_b));
  endtask

  initial begin
    vecs[0] = '{11'h7FF, {16{8'hA5}}};
    vecs[1] = '{11'h000, {128{1'b1}}};
    vecs[2] = '{11'h400, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    vecs[3] = '{11'h001, 128'h1};
    vecs[4] = '{11'h2AA, 128'h8000_0000_0000_0000_0000_0000_0000_0000};

    rst_n       = 1'b0;
    ram_if.wadr = '0;
    ram_if.wdat = '0;
    ram_if.radr = '0;
    idle();
    step();
    step();
    check("reset.rdat", ram_if.rdat, '0);
    check("reset.rsbe", 128'(ram_if.rsbe), '0);
    check("reset.rdbe", 128'(ram_if.rdbe), '0);
    rst_n = 1'b1;
    step();

    // Table: write every vector, then read each back.
    for (int i = 0; i < 5; i++) write(vecs[i].addr, vecs[i].dat, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dat, 1'b0, 1'b0);

    // Output hold after the last read.
    step();
    step();
    check("hold.rdat", ram_if.rdat, vecs[4].dat);

    // Back-to-back reads of locations holding their own address.
    for (int i = 0; i < 4; i++) write(11'(i), 128'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ram_if.ren  = 1'b1;
      ram_if.radr = 11'(i);
      step();
      if (i > 0) check($sformatf("b2b%0d.rdat", i - 1), ram_if.rdat, 128'(i - 1));
    end
    ram_if.ren = 1'b0;
    step();
    check("b2b3.rdat", ram_if.rdat, 128'd3);
    step();
    check("b2b.hold", ram_if.rdat, 128'd3);

    // Collision at address 5: read-first, then the new word.
    write(11'd5, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 1'b0, 1'b0);
    ram_if.wen  = 1'b1;
    ram_if.wadr = 11'd5;
    ram_if.wdat = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    ram_if.ren  = 1'b1;
    ram_if.radr = 11'd5;
    step();
    idle();
    step();
    check("coll.old", ram_if.rdat, 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF);
    read_check("coll.new", 11'd5, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b0);

    // Concurrent write and read to different addresses.
    ram_if.wen  = 1'b1;
    ram_if.wadr = 11'd6;
    ram_if.wdat = 128'h6666;
    ram_if.ren  = 1'b1;
    ram_if.radr = 11'h7FF;
    step();
    idle();
    step();
    check("diff.rd", ram_if.rdat, {16{8'hA5}});
    read_check("diff.wr", 11'd6, 128'h6666, 1'b0, 1'b0);

    // Reset mid-read; a write held during reset must be dropped.
    ram_if.ren  = 1'b1;
    ram_if.radr = 11'h2AA;
    step();
    ram_if.ren  = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("rstmid.rdat", ram_if.rdat, '0);
    check("rstmid.rsbe", 128'(ram_if.rsbe), '0);
    ram_if.wen  = 1'b1;
    ram_if.wadr = 11'h7FF;
    ram_if.wdat = '0;
    step();
    idle();
    rst_n = 1'b1;
    step();
    check("rstpost1.rdat", ram_if.rdat, '0);
    step();
    check("rstpost2.rdat", ram_if.rdat, '0);
    read_check("rstwr", 11'h7FF, {16{8'hA5}}, 1'b0, 1'b0);

    // Error injection: corrected with rsbe under ECC, ignored otherwise.
    write(11'h010, 128'h1234, 1'b1, 1'b0);
    read_check("sbe", 11'h010, 128'h1234, ECC_ON, 1'b0);
    step();
    check("sbe.pulse", 128'(ram_if.rsbe), '0);
    write(11'h011, 128'h1234, 1'b1, 1'b1);
    read_check("dbe", 11'h011, ECC_ON ? 128'h1237 : 128'h1234, 1'b0, ECC_ON);
    step();
    check("dbe.pulse", 128'(ram_if.rdbe), '0);
    check("dbe.hold", ram_if.rdat, ECC_ON ? 128'h1237 : 128'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
